// File: rtl/soc_bus_fabric.sv
// Two-master, NSLV-slave single-outstanding bus fabric with fixed m1 priority,
// address-slot decode, read timeout and error signalling.
module soc_bus_fabric #(
  parameter int XLEN       = 32,
  parameter int NSLV       = 4,
  parameter int SLOT_SHIFT = 11,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rstB,
  input  logic [XLEN-1:0]      m0Addr,
  input  logic [XLEN-1:0]      m1Addr,
  input  logic [XLEN-1:0]      m0WrData,
  input  logic [XLEN-1:0]      m1WrData,
  input  logic                 m0WrEn,
  input  logic                 m1WrEn,
  input  logic                 m0RdEn,
  input  logic                 m1RdEn,
  input  logic [3:0]           m0Mode,
  input  logic [3:0]           m1Mode,
  output logic                 m0Stall,
  output logic                 m1Stall,
  output logic [XLEN-1:0]      m0RdData,
  output logic [XLEN-1:0]      m1RdData,
  output logic                 m0RdValid,
  output logic                 m1RdValid,
  output logic                 busErr,
  output logic                 errMaster,
  output logic [XLEN-1:0]      sAddr,
  output logic [XLEN-1:0]      sWrData,
  output logic [3:0]           sMode,
  output logic [NSLV-1:0]      sWrEn,
  output logic [NSLV-1:0]      sRdEn,
  input  logic [NSLV*XLEN-1:0] sRdData,
  input  logic [NSLV-1:0]      sRdValid
);

  localparam int SELW = $clog2(NSLV);
  localparam int CNTW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ERR_RSP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic [SELW-1:0]   slot_q, slot_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [XLEN-1:0]   m0_rdata_q, m0_rdata_d;
  logic [XLEN-1:0]   m1_rdata_q, m1_rdata_d;
  logic              bus_err_q, bus_err_d;
  logic              err_master_q, err_master_d;

  logic              m0_req, m1_req, req_any;
  logic              req_owner, req_wr, req_rd, req_mapped;
  logic [XLEN-1:0]   req_addr;
  logic [SELW-1:0]   req_slot;
  logic [NSLV-1:0]   req_onehot;
  logic              own_valid;
  logic [XLEN-1:0]   own_data;
  logic              rsp_valid, rsp_err, rsp_master;
  logic [XLEN-1:0]   rsp_data;

  // m1 (programmer) wins whenever it requests.
  assign m0_req    = m0WrEn | m0RdEn;
  assign m1_req    = m1WrEn | m1RdEn;
  assign req_any   = m0_req | m1_req;
  assign req_owner = m1_req;
  assign req_addr  = req_owner ? m1Addr : m0Addr;
  assign req_wr    = req_owner ? m1WrEn : m0WrEn;
  assign req_rd    = req_owner ? m1RdEn : m0RdEn;

  assign req_slot   = req_addr[SLOT_SHIFT +: SELW];
  assign req_mapped = (int'(req_slot) < NSLV) &&
                      ((req_addr >> (SLOT_SHIFT + SELW)) == '0);
  assign req_onehot = NSLV'(1) << req_slot;

  assign sAddr   = req_addr;
  assign sWrData = req_owner ? m1WrData : m0WrData;
  assign sMode   = req_owner ? m1Mode : m0Mode;

  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (slot_q == SELW'(k)) begin
        own_valid = sRdValid[k];
        own_data  = sRdData[k*XLEN +: XLEN];
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    slot_d       = slot_q;
    m0_rvalid_d  = 1'b0;
    m1_rvalid_d  = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    bus_err_d    = 1'b0;
    err_master_d = err_master_q;
    rsp_valid    = 1'b0;
    rsp_err      = 1'b0;
    rsp_master   = 1'b0;
    rsp_data     = '0;
    sWrEn        = '0;
    sRdEn        = '0;
    m0Stall      = 1'b0;
    m1Stall      = 1'b0;

    case (state_q)
      IDLE: begin
        m0Stall = m0_req & m1_req;
        cnt_d   = '0;
        if (req_any) begin
          if (req_wr) begin
            // A combined write+read performs the write and flags the read.
            if (req_mapped) sWrEn = req_onehot;
            rsp_err    = !req_mapped || req_rd;
            rsp_master = req_owner;
          end else if (req_mapped) begin
            sRdEn   = req_onehot;
            owner_d = req_owner;
            slot_d  = req_slot;
            state_d = RD_WAIT;
          end else begin
            rsp_valid  = 1'b1;
            rsp_err    = 1'b1;
            rsp_master = req_owner;
            state_d    = ERR_RSP;
          end
        end
      end
      RD_WAIT: begin
        m0Stall = m0_req;
        m1Stall = m1_req;
        cnt_d   = cnt_q + 1'b1;
        if (own_valid) begin
          rsp_valid  = 1'b1;
          rsp_data   = own_data;
          rsp_master = owner_q;
          state_d    = IDLE;
        end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          rsp_valid  = 1'b1;
          rsp_err    = 1'b1;
          rsp_master = owner_q;
          state_d    = IDLE;
        end
      end
      ERR_RSP: begin
        m0Stall = m0_req;
        m1Stall = m1_req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rsp_valid) begin
      if (rsp_master) begin
        m1_rvalid_d = 1'b1;
        m1_rdata_d  = rsp_data;
      end else begin
        m0_rvalid_d = 1'b1;
        m0_rdata_d  = rsp_data;
      end
    end
    if (rsp_err) begin
      bus_err_d    = 1'b1;
      err_master_d = rsp_master;
    end

    // Slaves and masters see a quiet bus while reset is held.
    if (!rstB) begin
      sWrEn   = '0;
      sRdEn   = '0;
      m0Stall = 1'b0;
      m1Stall = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the reset is synchronous, so it sits inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstB) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      slot_q       <= '0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      bus_err_q    <= 1'b0;
      err_master_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      slot_q       <= slot_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      bus_err_q    <= bus_err_d;
      err_master_q <= err_master_d;
    end
  end

  assign m0RdValid = m0_rvalid_q;
  assign m1RdValid = m1_rvalid_q;
  assign m0RdData  = m0_rdata_q;
  assign m1RdData  = m1_rdata_q;
  assign busErr    = bus_err_q;
  assign errMaster = err_master_q;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: a default 4-slot instance plus an
// 8-slot instance for wide-decode checks.
module tb_soc_bus_fabric;

  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstB;
  logic [31:0]  m0Addr, m1Addr, m0WrData, m1WrData;
  logic         m0WrEn, m1WrEn, m0RdEn, m1RdEn;
  logic [3:0]   m0Mode, m1Mode;
  logic         m0Stall, m1Stall, m0RdValid, m1RdValid, busErr, errMaster;
  logic [31:0]  m0RdData, m1RdData, sAddr, sWrData;
  logic [3:0]   sMode, sWrEn, sRdEn, sRdValid;
  logic [127:0] sRdData;

  logic [31:0]  b_m0Addr, b_m1Addr, b_m0WrData, b_m1WrData;
  logic         b_m0WrEn, b_m1WrEn, b_m0RdEn, b_m1RdEn;
  logic [3:0]   b_m0Mode, b_m1Mode;
  logic         b_m0Stall, b_m1Stall, b_m0RdValid, b_m1RdValid, b_busErr, b_errMaster;
  logic [31:0]  b_m0RdData, b_m1RdData, b_sAddr, b_sWrData;
  logic [3:0]   b_sMode;
  logic [7:0]   b_sWrEn, b_sRdEn, b_sRdValid;
  logic [255:0] b_sRdData;

  int n_cmp = 0;
  int n_err = 0;
  int early;

  soc_bus_fabric #(.XLEN(32), .NSLV(4), .SLOT_SHIFT(11), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rstB(rstB),
    .m0Addr(m0Addr), .m1Addr(m1Addr), .m0WrData(m0WrData), .m1WrData(m1WrData),
    .m0WrEn(m0WrEn), .m1WrEn(m1WrEn), .m0RdEn(m0RdEn), .m1RdEn(m1RdEn),
    .m0Mode(m0Mode), .m1Mode(m1Mode), .m0Stall(m0Stall), .m1Stall(m1Stall),
    .m0RdData(m0RdData), .m1RdData(m1RdData), .m0RdValid(m0RdValid), .m1RdValid(m1RdValid),
    .busErr(busErr), .errMaster(errMaster), .sAddr(sAddr), .sWrData(sWrData),
    .sMode(sMode), .sWrEn(sWrEn), .sRdEn(sRdEn), .sRdData(sRdData), .sRdValid(sRdValid)
  );

  soc_bus_fabric #(.XLEN(32), .NSLV(8), .SLOT_SHIFT(11), .TIMEOUT(TO)) u_dut8 (
    .clk(clk), .rstB(rstB),
    .m0Addr(b_m0Addr), .m1Addr(b_m1Addr), .m0WrData(b_m0WrData), .m1WrData(b_m1WrData),
    .m0WrEn(b_m0WrEn), .m1WrEn(b_m1WrEn), .m0RdEn(b_m0RdEn), .m1RdEn(b_m1RdEn),
    .m0Mode(b_m0Mode), .m1Mode(b_m1Mode), .m0Stall(b_m0Stall), .m1Stall(b_m1Stall),
    .m0RdData(b_m0RdData), .m1RdData(b_m1RdData), .m0RdValid(b_m0RdValid), .m1RdValid(b_m1RdValid),
    .busErr(b_busErr), .errMaster(b_errMaster), .sAddr(b_sAddr), .sWrData(b_sWrData),
    .sMode(b_sMode), .sWrEn(b_sWrEn), .sRdEn(b_sRdEn), .sRdData(b_sRdData), .sRdValid(b_sRdValid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge, where inputs change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0Addr = '0; m1Addr = '0; m0WrData = '0; m1WrData = '0;
    m0WrEn = 1'b0; m1WrEn = 1'b0; m0RdEn = 1'b0; m1RdEn = 1'b0;
    m0Mode = '0; m1Mode = '0; sRdValid = '0;
    b_m0Addr = '0; b_m1Addr = '0; b_m0WrData = '0; b_m1WrData = '0;
    b_m0WrEn = 1'b0; b_m1WrEn = 1'b0; b_m0RdEn = 1'b0; b_m1RdEn = 1'b0;
    b_m0Mode = '0; b_m1Mode = '0; b_sRdValid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sRdData   = '0;
    b_sRdData = '0;
    clear_inputs();
    rstB   = 1'b0;
    m0Addr = 32'h0000_0804; m0RdEn = 1'b1;
    m1Addr = 32'h0000_0800; m1RdEn = 1'b1;
    repeat (3) step();
    #2;
    check("rst_srden", sRdEn, 4'b0000);
    check("rst_swren", sWrEn, 4'b0000);
    check("rst_m0stall", m0Stall, 1'b0);
    check("rst_m1stall", m1Stall, 1'b0);
    check("rst_m0rvalid", m0RdValid, 1'b0);
    check("rst_m0rdata", m0RdData, 32'h0);
    check("rst_buserr", busErr, 1'b0);
    check("rst_errmaster", errMaster, 1'b0);

    step();
    clear_inputs();
    rstB = 1'b1;
    step();

    // Slot-1 read with one-cycle slave latency.
    m0Addr = 32'h0000_0804; m0RdEn = 1'b1; m0Mode = 4'h2;
    #2;
    check("rd_strobe", sRdEn, 4'b0010);
    check("rd_addr", sAddr, 32'h0000_0804);
    check("rd_mode", sMode, 4'h2);
    step();
    m0RdEn = 1'b0; sRdValid = 4'b0010; sRdData[32 +: 32] = 32'h1234_5678;
    #2;
    check("rd_strobe_once", sRdEn, 4'b0000);
    check("rd_not_early", m0RdValid, 1'b0);
    step();
    sRdValid = 4'b0000;
    #2;
    check("rd_valid", m0RdValid, 1'b1);
    check("rd_data", m0RdData, 32'h1234_5678);
    check("rd_no_err", busErr, 1'b0);
    check("rd_m1_quiet", m1RdValid, 1'b0);
    step();
    sRdValid = 4'b0100;
    #2;
    check("rd_pulse", m0RdValid, 1'b0);
    check("rd_hold", m0RdData, 32'h1234_5678);
    step();
    sRdValid = 4'b0000;
    #2;
    check("idle_stray_valid", {m1RdValid, m0RdValid}, 2'b00);

    // Simultaneous writes: m1 first, m0 held and strobed next cycle.
    m0Addr = 32'h0000_0000; m0WrData = 32'hAAAA_0000; m0WrEn = 1'b1;
    m1Addr = 32'h0000_1000; m1WrData = 32'hBBBB_1111; m1WrEn = 1'b1;
    #2;
    check("arb_swren_m1", sWrEn, 4'b0100);
    check("arb_wdata_m1", sWrData, 32'hBBBB_1111);
    check("arb_m0stall", m0Stall, 1'b1);
    check("arb_m1stall", m1Stall, 1'b0);
    step();
    m1WrEn = 1'b0;
    #2;
    check("arb_swren_m0", sWrEn, 4'b0001);
    check("arb_wdata_m0", sWrData, 32'hAAAA_0000);
    check("arb_m0go", m0Stall, 1'b0);
    step();
    m0WrEn = 1'b0;
    #2;
    check("arb_no_err", busErr, 1'b0);

    // Slot-2 read with no slave answer: timeout response.
    m0Addr = 32'h0000_1000; m0RdEn = 1'b1;
    #2;
    check("to_strobe", sRdEn, 4'b0100);
    early = 0;
    for (int k = 1; k <= TO; k++) begin
      step();
      m0RdEn   = 1'b0;
      m1WrEn   = (k == 2);
      sRdValid = (k == 3) ? 4'b0010 : 4'b0000;
      #2;
      if (k == 2) begin
        check("wait_m1stall", m1Stall, 1'b1);
        check("wait_no_strobe", sWrEn, 4'b0000);
      end
      early += int'(m0RdValid) + int'(busErr);
    end
    step();
    clear_inputs();
    #2;
    check("to_not_early", early, 0);
    check("to_valid", m0RdValid, 1'b1);
    check("to_data", m0RdData, 32'h0);
    check("to_err", busErr, 1'b1);
    check("to_errmaster", errMaster, 1'b0);
    step();

    // Unmapped read from m1.
    m1Addr = 32'h0001_0000; m1RdEn = 1'b1;
    #2;
    check("um_rd_no_srden", sRdEn, 4'b0000);
    check("um_rd_no_swren", sWrEn, 4'b0000);
    step();
    m1RdEn = 1'b0;
    #2;
    check("um_rd_valid", m1RdValid, 1'b1);
    check("um_rd_data", m1RdData, 32'h0);
    check("um_rd_err", busErr, 1'b1);
    check("um_rd_errmaster", errMaster, 1'b1);
    step();
    #2;
    check("um_rd_err_pulse", busErr, 1'b0);

    // Unmapped write from m0.
    m0Addr = 32'h8000_0000; m0WrEn = 1'b1;
    #2;
    check("um_wr_no_strobe", sWrEn, 4'b0000);
    step();
    m0WrEn = 1'b0;
    #2;
    check("um_wr_err", busErr, 1'b1);
    check("um_wr_errmaster", errMaster, 1'b0);
    step();

    // Write and read together from m1: write done, read flagged.
    m1Addr = 32'h0000_0800; m1WrData = 32'h0000_0055; m1WrEn = 1'b1; m1RdEn = 1'b1;
    #2;
    check("wr_rd_swren", sWrEn, 4'b0010);
    check("wr_rd_srden", sRdEn, 4'b0000);
    step();
    m1WrEn = 1'b0; m1RdEn = 1'b0;
    #2;
    check("wr_rd_err", busErr, 1'b1);
    check("wr_rd_errmaster", errMaster, 1'b1);
    check("wr_rd_no_rvalid", m1RdValid, 1'b0);
    step();

    // Reset in the middle of a read, then a fresh read.
    m0Addr = 32'h0000_0804; m0RdEn = 1'b1;
    #2;
    check("rr_strobe", sRdEn, 4'b0010);
    step();
    m0RdEn = 1'b0; rstB = 1'b0;
    step();
    rstB = 1'b1;
    step();
    sRdValid = 4'b0010; sRdData[32 +: 32] = 32'hDEAD_BEEF;
    step();
    sRdValid = 4'b0000;
    #2;
    check("rr_no_rvalid", m0RdValid, 1'b0);
    check("rr_rdata_cleared", m0RdData, 32'h0);
    m0Addr = 32'h0000_1804; m0RdEn = 1'b1;
    #2;
    check("rr_next_strobe", sRdEn, 4'b1000);
    step();
    m0RdEn = 1'b0; sRdValid = 4'b1000; sRdData[96 +: 32] = 32'hCAFE_F00D;
    step();
    sRdValid = 4'b0000;
    #2;
    check("rr_next_valid", m0RdValid, 1'b1);
    check("rr_next_data", m0RdData, 32'hCAFE_F00D);

    // Eight-slot decode.
    b_m0Addr = 32'h0000_3800; b_m0WrEn = 1'b1;
    #2;
    check("n8_slot7", b_sWrEn, 8'h80);
    step();
    b_m0Addr = 32'h0000_4000;
    #2;
    check("n8_unmapped_no_strobe", b_sWrEn, 8'h00);
    check("n8_mapped_no_err", b_busErr, 1'b0);
    step();
    b_m0WrEn = 1'b0;
    #2;
    check("n8_unmapped_err", b_busErr, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/soc_bus_fabric.md
SOC_BUS_FABRIC -- requirements
Module: soc_bus_fabric

Interface
REQ-001 Parameter XLEN, 32: data/address width.
REQ-002 Parameter NSLV, 4: slave slot count, 2..16.
REQ-003 Parameter SLOT_SHIFT, 11: lowest address bit of the slot index; SELW = $clog2(NSLV) bits above it select the slot.
REQ-004 Parameter TIMEOUT, 16: max RD_WAIT cycles before error response, >=2.
REQ-005 clk input 1: single clock; all logic on rising edge.
REQ-006 rstB input 1: reset, synchronous, active-low.
REQ-007 m0Addr/m1Addr input XLEN each: master address (m0 = core, m1 = programmer).
REQ-008 m0WrData/m1WrData input XLEN: write data.
REQ-009 m0WrEn/m1WrEn, m0RdEn/m1RdEn input 1 each: single-cycle request strobes.
REQ-010 m0Mode/m1Mode input 4: access mode {byte,half,word,unsigned}, forwarded to slaves.
REQ-011 m0Stall/m1Stall output 1: request not accepted this cycle; master holds it.
REQ-012 m0RdData/m1RdData output XLEN, m0RdValid/m1RdValid output 1: registered read response.
REQ-013 busErr output 1: one-cycle error pulse; errMaster output 1: master owning the error.
REQ-014 sAddr output XLEN, sWrData output XLEN, sMode output 4: shared slave-side request fields.
REQ-015 sWrEn/sRdEn output NSLV: one-hot per-slot strobes.
REQ-016 sRdData input NSLV*XLEN (slot k at [k*XLEN +: XLEN]), sRdValid input NSLV: slave responses.

Function
REQ-017 Address maps to slot k when addr[SLOT_SHIFT +: SELW]==k, k<NSLV, and addr[XLEN-1:SLOT_SHIFT+SELW]==0; otherwise unmapped.
REQ-018 FSM states IDLE, RD_WAIT, ERR_RSP; reset state IDLE.
REQ-019 IDLE: a master requests when WrEn|RdEn; m1 has fixed priority; loser gets Stall=1 in the same cycle.
REQ-020 Accepted request drives sAddr/sWrData/sMode and the selected slot strobe combinationally in the acceptance cycle; unselected strobes 0.
REQ-021 Accepted mapped write: single cycle, FSM stays IDLE, no response.
REQ-022 Accepted mapped read: FSM -> RD_WAIT, latch owner and slot, clear timeout counter.
REQ-023 RD_WAIT: both Stall=1 on any request; all slave strobes 0; counter increments each cycle.
REQ-024 RD_WAIT, sRdValid[slot]=1: next cycle owner RdValid=1 with RdData=sRdData[slot]; FSM -> IDLE same edge.
REQ-025 RD_WAIT, counter reaches TIMEOUT-1 without valid: next cycle owner RdValid=1, RdData=0, busErr=1, errMaster=owner; FSM -> IDLE.
REQ-026 sRdValid from non-owned slot or in IDLE is ignored.
REQ-027 Unmapped read: no strobe; FSM -> ERR_RSP; next cycle RdValid=1, RdData=0, busErr=1; ERR_RSP -> IDLE unconditionally.
REQ-028 Unmapped write: no strobe, dropped; busErr=1 next cycle; FSM stays IDLE.
REQ-029 WrEn and RdEn together from the granted master: write performed, read dropped, busErr=1 next cycle.
REQ-030 RdValid, busErr are one-cycle pulses; RdData holds last value between pulses.
REQ-031 Min read latency, strobe to RdValid: slave latency + 1 cycle.

Reset
REQ-032 rstB=0 at edge: FSM IDLE, counter 0, RdValid=0, RdData=0, busErr=0, errMaster=0.
REQ-033 During reset all sWrEn/sRdEn=0 and Stall=0.
REQ-034 Reset during RD_WAIT aborts read; late sRdValid after reset produces no response.

Verification
REQ-035 m0 read 0x0000_0804 (slot 1), slave valid 1 cycle later data 0x1234_5678 -> sRdEn=0b0010 one cycle, m0RdValid 2 cycles after strobe, m0RdData=0x1234_5678.
REQ-036 m0 and m1 write same cycle -> m1 write strobed, m0Stall=1; m0 held, strobed next cycle.
REQ-037 m0 read slot 2, no slave valid -> m0RdValid=1, RdData=0, busErr=1 exactly TIMEOUT+1 cycles after strobe.
REQ-038 m1 read 0x0001_0000 (unmapped) -> no strobe, next cycle m1RdValid=1, busErr=1, errMaster=1.
REQ-039 Reset asserted in RD_WAIT, slave valid 1 cycle after release -> no RdValid, FSM IDLE, next read completes normally.
REQ-040 NSLV=8, m0 write 0x0000_3800 -> sWrEn=0x80; write 0x0000_4000 -> busErr=1, no strobe.
